heichips25_project_mux: RTL and testbench

Parametrised multi-project selector for the tiny-tile top: it replaces the fixed two-project wrapper.
- Hosts up to NUM_PROJECTS user designs behind one 8+8+8 pin interface.
- Provides a runtime configuration mode, a guaranteed per-project reset sequence on every switch, and an in-band escape back to configuration.
- Sits between the tile pins and the project instances: projects take ui_in/uio_in directly, and this block gates their ena/rst_n and muxes their outputs.

---
 rtl/heichips25_project_mux.sv | 195 +++++++++++++++++++
 tb/tb_heichips25_project_mux.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/heichips25_project_mux.sv
// heichips25_project_mux: runtime selector for up to NUM_PROJECTS tiny-tile
// user designs. It provides a CFG mode that selects a slot, a guaranteed
// reset hold on every switch, and an in-band escape from RUN back to CFG.
// Optional build macro: MUX_OUTPUT_REG_EN adds one register stage on
// uo_out/uio_out/uio_oe. Without it, the output path is combinational.
module heichips25_project_mux #(
  parameter int unsigned NUM_PROJECTS = 4,
  parameter int unsigned RST_CYCLES   = 8,
  parameter int unsigned ESC_CYCLES   = 16,
  parameter logic [7:0]  ESC_PATTERN  = 8'hA5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ena,
  input  logic [7:0]                ui_in,
  input  logic [7:0]                uio_in,
  output logic [7:0]                uo_out,
  output logic [7:0]                uio_out,
  output logic [7:0]                uio_oe,
  output logic [NUM_PROJECTS-1:0]   proj_ena,
  output logic [NUM_PROJECTS-1:0]   proj_rst_n,
  input  logic [8*NUM_PROJECTS-1:0] proj_uo_out,
  input  logic [8*NUM_PROJECTS-1:0] proj_uio_out,
  input  logic [8*NUM_PROJECTS-1:0] proj_uio_oe
);

  typedef enum logic [1:0] {
    ST_CFG        = 2'd0,
    ST_RESET_HOLD = 2'd1,
    ST_RUN        = 2'd2
  } state_t;

  state_t                  state;
  logic [3:0]              sel;
  logic                    err;
  logic [7:0]              hold_cnt;
  logic [7:0]              esc_cnt;

  logic                    wr_s1, wr_s2, wr_d;
  logic                    cm_s1, cm_s2, cm_d;
  logic                    wr_ev, cm_ev;
  logic                    sel_ok;
  logic                    esc_hit;

  logic [NUM_PROJECTS-1:0] proj_ena_q;
  logic [NUM_PROJECTS-1:0] proj_rst_n_q;

  logic [7:0]              mux_uo, mux_uio, mux_oe;
  logic [7:0]              nxt_uo, nxt_uio, nxt_oe;

  logic                    unused_uio;

  // The remaining bidir inputs belong to the projects and are not used here
  assign unused_uio = ^uio_in[5:0];

  // Strobe synchronisers and edge detectors. They keep running while ena=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_s1 <= 1'b0;
      wr_s2 <= 1'b0;
      wr_d  <= 1'b0;
      cm_s1 <= 1'b0;
      cm_s2 <= 1'b0;
      cm_d  <= 1'b0;
    end else begin
      wr_s1 <= uio_in[7];
      wr_s2 <= wr_s1;
      wr_d  <= wr_s2;
      cm_s1 <= uio_in[6];
      cm_s2 <= cm_s1;
      cm_d  <= cm_s2;
    end
  end

  assign wr_ev   = wr_s2 & ~wr_d;
  assign cm_ev   = cm_s2 & ~cm_d;
  assign sel_ok  = ({1'b0, ui_in[3:0]} < 5'(NUM_PROJECTS));
  assign esc_hit = (ui_in == ESC_PATTERN) && (uio_in[7:6] == 2'b11);

  // Control FSM. Per-slot enable and reset are registered from the current
  // state, so a slot follows its state one clock later. Nothing here advances
  // while ena=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_CFG;
      sel          <= '0;
      err          <= 1'b0;
      hold_cnt     <= '0;
      esc_cnt      <= '0;
      proj_ena_q   <= '0;
      proj_rst_n_q <= '0;
    end else if (ena) begin
      for (int unsigned i = 0; i < NUM_PROJECTS; i++) begin
        proj_ena_q[i]   <= (state != ST_CFG) && (sel == 4'(i));
        proj_rst_n_q[i] <= (state == ST_RUN) && (sel == 4'(i));
      end
      case (state)
        ST_CFG: begin
          esc_cnt <= '0;
          // The commit takes effect on the following state. Because of that,
          // a write in the same cycle is already visible as sel.
          if (wr_ev) begin
            if (sel_ok) begin
              sel <= ui_in[3:0];
              err <= 1'b0;
            end else begin
              err <= 1'b1;
            end
          end
          if (cm_ev) begin
            state    <= ST_RESET_HOLD;
            hold_cnt <= '0;
          end
        end
        ST_RESET_HOLD: begin
          if (hold_cnt == 8'(RST_CYCLES - 1)) begin
            state    <= ST_RUN;
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        ST_RUN: begin
          if (esc_hit) begin
            if (esc_cnt == 8'(ESC_CYCLES - 1)) begin
              state   <= ST_CFG;
              esc_cnt <= '0;
            end else begin
              esc_cnt <= esc_cnt + 8'd1;
            end
          end else begin
            esc_cnt <= '0;
          end
        end
        default: state <= ST_CFG;
      endcase
    end
  end

  assign proj_ena   = proj_ena_q & {NUM_PROJECTS{ena}};
  assign proj_rst_n = proj_rst_n_q;

  // Select the output buses of slot sel
  always_comb begin
    mux_uo  = '0;
    mux_uio = '0;
    mux_oe  = '0;
    for (int unsigned i = 0; i < NUM_PROJECTS; i++) begin
      if (sel == 4'(i)) begin
        mux_uo  = proj_uo_out[8*i +: 8];
        mux_uio = proj_uio_out[8*i +: 8];
        mux_oe  = proj_uio_oe[8*i +: 8];
      end
    end
  end

  // Pin outputs by state: status word in CFG, silence in reset hold, and the
  // selected project's buses in RUN
  always_comb begin
    nxt_uo  = '0;
    nxt_uio = '0;
    nxt_oe  = '0;
    if (ena) begin
      case (state)
        ST_CFG: nxt_uo = {sel, err, 3'b101};
        ST_RUN: begin
          nxt_uo  = mux_uo;
          nxt_uio = mux_uio;
          nxt_oe  = mux_oe;
        end
        default: ;
      endcase
    end
  end

`ifdef MUX_OUTPUT_REG_EN
  // Retimed output stage. The reset value matches the CFG status word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uo_out  <= 8'h05;
      uio_out <= '0;
      uio_oe  <= '0;
    end else begin
      uo_out  <= nxt_uo;
      uio_out <= nxt_uio;
      uio_oe  <= nxt_oe;
    end
  end
`else
  assign uo_out  = nxt_uo;
  assign uio_out = nxt_uio;
  assign uio_oe  = nxt_oe;
`endif

endmodule

// File: tb/tb_heichips25_project_mux.sv
// Bench for heichips25_project_mux. It keeps an event-level reference model
// and compares every cycle at the falling edge. It also pins the model with
// literal status values and measured reset-hold lengths.
module tb_heichips25_project_mux;
  localparam int NP = 4;
  localparam int RC = 8;
  localparam int EC = 16;

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b1;
  logic          ena    = 1'b1;
  logic [7:0]    ui_in  = '0;
  logic [7:0]    uio_in = '0;
  logic [7:0]    uo_out, uio_out, uio_oe;
  logic [NP-1:0] proj_ena, proj_rst_n;
  logic [8*NP-1:0] proj_uo_out  = '0;
  logic [8*NP-1:0] proj_uio_out = '0;
  logic [8*NP-1:0] proj_uio_oe  = '0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  heichips25_project_mux #(
    .NUM_PROJECTS(NP),
    .RST_CYCLES(RC),
    .ESC_CYCLES(EC),
    .ESC_PATTERN(8'hA5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe),
    .proj_ena(proj_ena), .proj_rst_n(proj_rst_n),
    .proj_uo_out(proj_uo_out), .proj_uio_out(proj_uio_out),
    .proj_uio_oe(proj_uio_oe)
  );

  // Project outputs change every cycle, well away from both clock edges
  always @(posedge clk) begin
    #2;
    proj_uo_out  = $urandom;
    proj_uio_out = $urandom;
    proj_uio_oe  = $urandom;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_mode = 0;              // 0 configuring, 1 holding reset, 2 running
  int m_sel = 0, m_err = 0, m_held = 0, m_esc = 0;
  int m_on = -1, m_run = -1;   // slot enabled / released, as seen by the slots
  bit [2:0] wr_hist = '0, cm_hist = '0;
  logic [23:0] r_out = {8'h05, 16'h0};

  function automatic logic [23:0] f_out();
    logic [7:0] u, io, oe;
    u = '0; io = '0; oe = '0;
    if (ena) begin
      if (m_mode == 0) u = {4'(m_sel), 1'(m_err), 3'b101};
      else if (m_mode == 2) begin
        u  = proj_uo_out[8*m_sel +: 8];
        io = proj_uio_out[8*m_sel +: 8];
        oe = proj_uio_oe[8*m_sel +: 8];
      end
    end
    return {u, io, oe};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit wr_ev, cm_ev;
    if (!rst_n) begin
      m_mode = 0; m_sel = 0; m_err = 0; m_held = 0; m_esc = 0;
      m_on = -1; m_run = -1; wr_hist = '0; cm_hist = '0;
      r_out = {8'h05, 16'h0};
    end else begin
      r_out = f_out();
      // A level seen two samples ago, after a low sample, is a usable event
      wr_ev = wr_hist[1] & ~wr_hist[2];
      cm_ev = cm_hist[1] & ~cm_hist[2];
      wr_hist = {wr_hist[1:0], uio_in[7]};
      cm_hist = {cm_hist[1:0], uio_in[6]};
      if (ena) begin
        m_on  = (m_mode != 0) ? m_sel : -1;
        m_run = (m_mode == 2) ? m_sel : -1;
        if (m_mode == 0) begin
          if (wr_ev) begin
            if (ui_in[3:0] < NP) begin m_sel = int'(ui_in[3:0]); m_err = 0; end
            else m_err = 1;
          end
          if (cm_ev) begin m_mode = 1; m_held = 0; end
        end else if (m_mode == 1) begin
          m_held++;
          if (m_held == RC) m_mode = 2;
        end else begin
          if (ui_in == 8'hA5 && uio_in[7:6] == 2'b11) m_esc++;
          else m_esc = 0;
          if (m_esc == EC) begin m_mode = 0; m_esc = 0; end
        end
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    logic [23:0] e;
    logic [NP-1:0] e_ena, e_rst;
`ifdef MUX_OUTPUT_REG_EN
    e = r_out;
`else
    e = f_out();
`endif
    for (int i = 0; i < NP; i++) begin
      e_ena[i] = ena && (i == m_on);
      e_rst[i] = (i == m_run);
    end
    chk("uo_out",     32'(uo_out),     32'(e[23:16]));
    chk("uio_out",    32'(uio_out),    32'(e[15:8]));
    chk("uio_oe",     32'(uio_oe),     32'(e[7:0]));
    chk("proj_ena",   32'(proj_ena),   32'(e_ena));
    chk("proj_rst_n", 32'(proj_rst_n), 32'(e_rst));
  end

  // Measure the length of each reset-hold interval: count the samples from
  // the first one where the slot is enabled but held, until it is released
  int low_len = 0, run_len = 0;
  bit counting = 0;
  always @(negedge clk) begin
    if (!counting && proj_ena[2] && !proj_rst_n[2]) begin
      counting = 1; run_len = 1;
    end else if (counting && !proj_rst_n[2]) begin
      run_len++;
    end else if (counting && proj_rst_n[2]) begin
      counting = 0; low_len = run_len;
    end
  end

  int low3 = 0, run3 = 0;
  bit cnt3 = 0;
  always @(negedge clk) begin
    if (!cnt3 && proj_ena[3] && !proj_rst_n[3]) begin
      cnt3 = 1; run3 = 1;
    end else if (cnt3 && !proj_rst_n[3]) begin
      run3++;
    end else if (cnt3 && proj_rst_n[3]) begin
      cnt3 = 0; low3 = run3;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic at_mid();
    @(negedge clk); #1;
  endtask

  task automatic wr(input logic [7:0] v);
    step(1);
    ui_in = v; uio_in[7] = 1'b1;
    step(1);
    uio_in[7] = 1'b0;
    step(4);
  endtask

  task automatic commit();
    step(1);
    uio_in[6] = 1'b1;
    step(1);
    uio_in[6] = 1'b0;
    step(4);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step(3);
    at_mid();
    chk("reset_uo",   32'(uo_out),     32'h05);
    chk("reset_rstn", 32'(proj_rst_n), 32'h0);
    chk("reset_ena",  32'(proj_ena),   32'h0);

    // Select slot 2, then commit and check the reset-hold length
    wr(8'h02);
    at_mid();
    chk("status_sel2", 32'(uo_out), 32'h25);
    commit();
    step(12);
    chk("hold_len", 32'(low_len), 32'(RC));
    at_mid();
`ifndef MUX_OUTPUT_REG_EN
    chk("run_mux", 32'(uo_out), 32'(proj_uo_out[23:16]));
`endif
    chk("run_rstn", 32'(proj_rst_n), 32'b0100);
    chk("run_ena",  32'(proj_ena),   32'b0100);

    // The escape pattern held for one cycle too few does nothing
    step(1);
    ui_in = 8'hA5; uio_in = 8'hC0;
    step(EC - 1);
    uio_in = 8'h00;
    step(1);
    at_mid();
    chk("esc15_stays_run", 32'(proj_rst_n), 32'b0100);
    step(1);
    uio_in = 8'hC0;
    step(EC);
    step(1);
    at_mid();
    chk("esc16_status", 32'(uo_out),     32'h25);
    chk("esc16_rstn",   32'(proj_rst_n), 32'h0);
    step(1);
    ui_in = 8'h00; uio_in = 8'h00;

    // A rejected write keeps sel and sets err. A commit with ena briefly low
    // during the hold restarts slot 2.
    wr(8'h07);
    at_mid();
    chk("bad_wr_status", 32'(uo_out), 32'h2D);
    commit();
    ena = 1'b0;
    step(5);
    ena = 1'b1;
    step(16);
    chk("gap_hold_len", 32'(low_len), 32'(RC + 5));
    at_mid();
    chk("gap_run_rstn", 32'(proj_rst_n), 32'b0100);

    // Asynchronous reset while running
    step(1);
    rst_n = 1'b0;
    #1;
    chk("arst_rstn", 32'(proj_rst_n), 32'h0);
    chk("arst_ena",  32'(proj_ena),   32'h0);
`ifndef MUX_OUTPUT_REG_EN
    chk("arst_uo",   32'(uo_out),     32'h05);
`endif
    step(2);
    rst_n = 1'b1;
    step(2);
    at_mid();
    chk("post_arst_uo", 32'(uo_out), 32'h05);

    // A write and a commit in the same cycle start the newly written slot
    step(1);
    ui_in = 8'h03; uio_in = 8'hC0;
    step(1);
    uio_in = 8'h00;
    step(4);
    step(12);
    chk("same_cycle_len", 32'(low3), 32'(RC));
    at_mid();
    chk("same_cycle_rstn", 32'(proj_rst_n), 32'b1000);
    step(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
